// File: rtl/dr_sched_pkg.sv
// Shared state types and parameter defaults for the dual-rail channel scheduler.
package dr_sched_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_REQ  = 2'd1,
    G_REL  = 2'd2,
    G_RUN  = 2'd3
  } go_state_t;

  typedef enum logic [1:0] {
    C_WAIT = 2'd0,
    C_PEND = 2'd1,
    C_ACK  = 2'd2
  } chan_state_t;

endpackage

// File: rtl/dr_chan_port.sv
// One dual-rail 4-phase input channel: completion/spacer/conflict detection,
// synchronizers for the handshake-level signals, the channel FSM and its ack.
module dr_chan_port
  import dr_sched_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             grant,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  output logic             req,
  output logic             ack,
  output logic             conflict
);

  chan_state_t            state;
  chan_state_t            state_nxt;
  logic                   complete;
  logic                   spacer;
  logic [SYNC_STAGES-1:0] complete_sync;
  logic [SYNC_STAGES-1:0] spacer_sync;
  logic                   complete_s;
  logic                   spacer_s;

  assign complete   = &(r0 | r1);
  assign spacer     = ~|(r0 | r1);
  assign conflict   = |(r0 & r1);
  assign complete_s = complete_sync[SYNC_STAGES-1];
  assign spacer_s   = spacer_sync[SYNC_STAGES-1];

  // A freshly synchronized completion requests immediately from C_WAIT, so a
  // grant in that cycle goes straight to C_ACK; otherwise the channel parks
  // in C_PEND. Kept outside the FSM block so grant never feeds back into req.
  assign req = (state == C_PEND) || ((state == C_WAIT) && enable && complete_s);
  assign ack = (state == C_ACK);

  // Only the level-type completion/spacer flags are synchronized; the data
  // rails are held stable by the sender until we acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      complete_sync <= '0;
      spacer_sync   <= '0;
    end else begin
      complete_sync[0] <= complete;
      spacer_sync[0]   <= spacer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        complete_sync[i] <= complete_sync[i-1];
        spacer_sync[i]   <= spacer_sync[i-1];
      end
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= C_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Channel FSM next state: wait for a complete word, hold it until granted,
  // then acknowledge until the sender returns to spacer.
  always_comb begin
    state_nxt = state;
    case (state)
      C_WAIT: begin
        if (enable && complete_s) begin
          state_nxt = grant ? C_ACK : C_PEND;
        end
      end
      C_PEND: begin
        if (grant) begin
          state_nxt = C_ACK;
        end
      end
      C_ACK: begin
        if (spacer_s) begin
          state_nxt = C_WAIT;
        end
      end
      default: state_nxt = C_WAIT;
    endcase
  end

endmodule

// File: rtl/dr_chan_sched.sv
// Scheduler between a Teak asynchronous top and a clocked stream: runs the go
// handshake, collects words from two dual-rail channels and forwards them
// through a one-entry valid/ready register with round-robin arbitration.
module dr_chan_sched
  import dr_sched_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             go_0r,
  input  logic             go_0a,
  input  logic [WIDTH-1:0] ch0_0r0,
  input  logic [WIDTH-1:0] ch0_0r1,
  output logic             ch0_0a,
  input  logic [WIDTH-1:0] ch1_0r0,
  input  logic [WIDTH-1:0] ch1_0r1,
  output logic             ch1_0a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             busy,
  output logic             err
);

  go_state_t              go_state;
  go_state_t              go_nxt;
  logic [SYNC_STAGES-1:0] go_ack_sync;
  logic                   go_ack_s;
  logic                   req0;
  logic                   req1;
  logic                   conflict0;
  logic                   conflict1;
  logic                   grant0;
  logic                   grant1;
  logic                   last_grant;
  logic                   reg_free;

  assign go_ack_s = go_ack_sync[SYNC_STAGES-1];
  assign go_0r    = (go_state == G_REQ);
  assign busy     = (go_state != G_IDLE);
  assign reg_free = !out_valid || out_ready;

  dr_chan_port #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_port0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (busy),
    .grant    (grant0),
    .r0       (ch0_0r0),
    .r1       (ch0_0r1),
    .req      (req0),
    .ack      (ch0_0a),
    .conflict (conflict0)
  );

  dr_chan_port #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_port1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (busy),
    .grant    (grant1),
    .r0       (ch1_0r0),
    .r1       (ch1_0r1),
    .req      (req1),
    .ack      (ch1_0a),
    .conflict (conflict1)
  );

  // Synchronizer for the asynchronous go acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_ack_sync <= '0;
    end else begin
      go_ack_sync[0] <= go_0a;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        go_ack_sync[i] <= go_ack_sync[i-1];
      end
    end
  end

  // Go FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_state <= G_IDLE;
    end else begin
      go_state <= go_nxt;
    end
  end

  // Go FSM next state: one full 4-phase cycle on the go channel, then run
  // until reset. start is only looked at while idle.
  always_comb begin
    go_nxt = go_state;
    case (go_state)
      G_IDLE:  if (start)     go_nxt = G_REQ;
      G_REQ:   if (go_ack_s)  go_nxt = G_REL;
      G_REL:   if (!go_ack_s) go_nxt = G_RUN;
      G_RUN:   go_nxt = G_RUN;
      default: go_nxt = G_IDLE;
    endcase
  end

  // Round-robin arbiter: a tie goes to the channel that was not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reg_free) begin
      if (req0 && req1) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (req0) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  // Output register: loads on grant (even in the cycle the old word drains),
  // otherwise clears valid once the consumer takes the word. err is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      err        <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        out_valid  <= 1'b1;
        out_data   <= grant1 ? ch1_0r1 : ch0_0r1;
        out_src    <= grant1;
        last_grant <= grant1;
        if ((grant0 && conflict0) || (grant1 && conflict1)) begin
          err <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dr_chan_sched.sv
// Self-checking bench for dr_chan_sched: table-driven single transfers,
// hand-written multi-cycle sequences and randomized rounds against a
// queue-based round-robin model.
module tb_dr_chan_sched;

  localparam int W    = 8;
  localparam int SYNC = 2;

  typedef struct {
    int           ch;
    logic [W-1:0] r1;
    logic [W-1:0] r0;
    logic [W-1:0] exp_data;
    logic         exp_src;
    logic         exp_err;
  } vec_t;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         go_0r;
  logic         go_0a;
  logic [W-1:0] ch0_0r0;
  logic [W-1:0] ch0_0r1;
  logic         ch0_0a;
  logic [W-1:0] ch1_0r0;
  logic [W-1:0] ch1_0r1;
  logic         ch1_0a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         busy;
  logic         err;

  logic         rand_ready;
  logic         rnd_ready;
  logic         man_ready;
  logic         mon_en;
  logic         hold_prev;
  logic [W:0]   prev_word;
  logic [W:0]   exp_q[$];
  logic [W:0]   got_q[$];
  int           model_last;
  int           n_compared;
  int           n_mismatched;
  vec_t         tbl[5];

  assign out_ready = rand_ready ? rnd_ready : man_ready;

  dr_chan_sched #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .go_0r     (go_0r),
    .go_0a     (go_0a),
    .ch0_0r0   (ch0_0r0),
    .ch0_0r1   (ch0_0r1),
    .ch0_0a    (ch0_0a),
    .ch1_0r0   (ch1_0r0),
    .ch1_0r1   (ch1_0r1),
    .ch1_0a    (ch1_0a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [W-1:0] r1, input logic [W-1:0] r0);
    if (ch == 0) begin
      ch0_0r1 = r1;
      ch0_0r0 = r0;
    end else begin
      ch1_0r1 = r1;
      ch1_0r0 = r0;
    end
  endtask

  function automatic logic ackOf(input int ch);
    return (ch == 0) ? ch0_0a : ch1_0a;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " go_0r"}, go_0r, 0);
    checkOutput({tag, " ch0_0a"}, ch0_0a, 0);
    checkOutput({tag, " ch1_0a"}, ch1_0a, 0);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out_data"}, out_data, 0);
    checkOutput({tag, " out_src"}, out_src, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " err"}, err, 0);
  endtask

  // Full sender-side 4-phase transfer on one channel: data, wait ack, spacer, wait ack low.
  task automatic send(input int ch, input logic [W-1:0] d);
    int n;
    @(negedge clk);
    applyStimulus(ch, d, ~d);
    n = 0;
    while (ackOf(ch) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput($sformatf("ch%0d ack rise timeout", ch), 0, 1);
    applyStimulus(ch, '0, '0);
    n = 0;
    while (ackOf(ch) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput($sformatf("ch%0d ack fall timeout", ch), 1, 0);
  endtask

  // Single transfer on an idle scheduler with out_ready=1, checking latency and result.
  task automatic runSingle(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    applyStimulus(v.ch, v.r1, v.r0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 20);
    checkOutput({tag, " latency"}, n, SYNC + 1);
    checkOutput({tag, " out_data"}, out_data, v.exp_data);
    checkOutput({tag, " out_src"}, out_src, v.exp_src);
    checkOutput({tag, " err"}, err, v.exp_err);
    checkOutput({tag, " ack with valid"}, ackOf(v.ch), 1);
    applyStimulus(v.ch, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ackOf(v.ch) !== 1'b0 && n < 20);
    checkOutput({tag, " ack fall after spacer"}, n, SYNC + 1);
  endtask

  task automatic goHandshake();
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("go_0r rise", go_0r, 1);
    checkOutput("busy in G_REQ", busy, 1);
    go_0a = 1'b1;
    n = 0;
    while (go_0r === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("go_0r fall latency", n, SYNC + 1);
    go_0a = 1'b0;
    repeat (SYNC + 3) @(negedge clk);
    checkOutput("busy in G_RUN", busy, 1);
    checkOutput("go_0r in G_RUN", go_0r, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start ignored in G_RUN", go_0r, 0);
  endtask

  // Reference model: tie -> the channel not granted last goes first.
  task automatic modelPredict(input int kind, input logic [W-1:0] d0, input logic [W-1:0] d1);
    if (kind == 0) begin
      exp_q.push_back({1'b0, d0});
      model_last = 0;
    end else if (kind == 1) begin
      exp_q.push_back({1'b1, d1});
      model_last = 1;
    end else if (model_last == 1) begin
      exp_q.push_back({1'b0, d0});
      exp_q.push_back({1'b1, d1});
      model_last = 1;
    end else begin
      exp_q.push_back({1'b1, d1});
      exp_q.push_back({1'b0, d0});
      model_last = 0;
    end
  endtask

  task automatic compareQueues(input string tag);
    checkOutput({tag, " word count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checkOutput($sformatf("%s word%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Randomized consumer readiness, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: records accepted words and checks words held under backpressure.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_prev) begin
        checkOutput("held out_valid", out_valid, 1);
        checkOutput("held word", {out_src, out_data}, prev_word);
      end
      if (out_valid && out_ready) got_q.push_back({out_src, out_data});
      hold_prev = out_valid && !out_ready;
      prev_word = {out_src, out_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    int n;
    int kind;
    logic [W-1:0] d0;
    logic [W-1:0] d1;

    n_compared   = 0;
    n_mismatched = 0;
    rand_ready   = 1'b0;
    rnd_ready    = 1'b1;
    man_ready    = 1'b1;
    mon_en       = 1'b0;
    hold_prev    = 1'b0;
    prev_word    = '0;
    reset_n      = 1'b0;
    start        = 1'b0;
    go_0a        = 1'b0;
    applyStimulus(0, '0, '0);
    applyStimulus(1, '0, '0);

    tbl[0] = '{0, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h3C, 8'hC3, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{0, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{1, 8'h0F, 8'hF8, 8'h0F, 1'b1, 1'b1};

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset_n = 1'b1;

    $display("[TB] channels ignored while idle");
    @(negedge clk);
    applyStimulus(0, 8'hA5, 8'h5A);
    repeat (6) @(negedge clk);
    checkOutput("idle ch0_0a", ch0_0a, 0);
    checkOutput("idle out_valid", out_valid, 0);
    applyStimulus(0, '0, '0);
    repeat (SYNC + 2) @(negedge clk);

    $display("[TB] go handshake");
    goHandshake();

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      runSingle(tbl[i], $sformatf("vec%0d", i));
    end

    $display("[TB] ties");
    man_ready = 1'b1;
    mon_en    = 1'b1;
    fork
      send(0, 8'h11);
      send(1, 8'h22);
    join
    send(0, 8'h55);
    fork
      send(0, 8'h33);
      send(1, 8'h44);
    join
    repeat (2) @(negedge clk);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'h44});
    exp_q.push_back({1'b0, 8'h33});
    mon_en = 1'b0;
    compareQueues("tie");

    $display("[TB] backpressure");
    @(negedge clk);
    man_ready = 1'b0;
    applyStimulus(0, 8'h5C, 8'hA3);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp first valid", out_valid, 1);
    applyStimulus(0, '0, '0);
    n = 0;
    while (ch0_0a !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(1, 8'h77, 8'h88);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp valid c%0d", c), out_valid, 1);
      checkOutput($sformatf("bp word c%0d", c), {out_src, out_data}, {1'b0, 8'h5C});
      checkOutput($sformatf("bp ch1 pending c%0d", c), ch1_0a, 0);
    end
    man_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release valid", out_valid, 1);
    checkOutput("bp release word", {out_src, out_data}, {1'b1, 8'h77});
    checkOutput("bp release ch1_0a", ch1_0a, 1);
    applyStimulus(1, '0, '0);
    n = 0;
    while (ch1_0a !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp ch1_0a fall", ch1_0a, 0);

    $display("[TB] random rounds");
    model_last = 1;
    mon_en     = 1'b1;
    @(negedge clk);
    rand_ready = 1'b1;
    for (int r = 0; r < 30; r++) begin
      kind = $urandom_range(0, 2);
      d0   = W'($urandom_range(0, 255));
      d1   = W'($urandom_range(0, 255));
      modelPredict(kind, d0, d1);
      if (kind == 0) begin
        send(0, d0);
      end else if (kind == 1) begin
        send(1, d1);
      end else begin
        fork
          send(0, d0);
          send(1, d1);
        join
      end
    end
    n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    @(negedge clk);
    rand_ready = 1'b0;
    man_ready  = 1'b1;
    compareQueues("random");
    checkOutput("err sticky", err, 1);

    $display("[TB] reset during C_ACK");
    @(negedge clk);
    applyStimulus(0, 8'h66, 8'h99);
    n = 0;
    while (ch0_0a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ch0 in C_ACK before reset", ch0_0a, 1);
    reset_n = 1'b0;
    #1;
    checkAllZero("mid-ack reset");
    applyStimulus(0, '0, '0);
    go_0a = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    goHandshake();
    runSingle('{1, 8'h99, 8'h66, 8'h99, 1'b1, 1'b0}, "post-reset");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
